// File: rtl/cpu_mem_pkg.sv
// Shared definitions for cpu_mem_responder: FSM states, the latched request
// snapshot, the no-store write-enable code and the timeout counter width.
package cpu_mem_pkg;

  localparam logic [3:0]  WEN_NONE = 4'hF;
  localparam int unsigned TO_CNT_W = 16;

  typedef logic [TO_CNT_W-1:0] to_cnt_t;

  typedef enum logic [2:0] {
    IDLE,
    DM_REQ,
    DM_RESP,
    IM_REQ,
    IM_RESP,
    DONE
  } state_e;

  // Request fields captured in IDLE; the CPU may change its pins afterwards.
  typedef struct packed {
    logic        im_rd;
    logic [29:0] im_word;
    logic        dm_rd;
    logic        dm_wr;
    logic [29:0] dm_word;
    logic [3:0]  dm_wstrb;
    logic [31:0] dm_wdata;
  } req_t;

  function automatic logic [31:0] word_addr(input logic [29:0] word);
    return {word, 2'b00};
  endfunction

endpackage

// File: rtl/mem_req_watchdog.sv
// Per-state wait counter for cpu_mem_responder; only built with MEM_TIMEOUT_EN.
// expired_o rises in the LIMIT-th consecutive cycle spent in one service state.
module mem_req_watchdog
  import cpu_mem_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  input  logic clear_i,
  output logic expired_o
);

  to_cnt_t cnt_q, cnt_d;

  // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!run_i || clear_i) begin
      cnt_d = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = run_i && (cnt_q == to_cnt_t'(LIMIT - 1));

endmodule

// File: rtl/cpu_mem_responder.sv
// Bridges a CPU's IM/DM ports onto a single grant/rvalid backend, DM beat first.
// Optional backend timeout with error pulse is enabled by defining MEM_TIMEOUT_EN.
module cpu_mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IM_ren,
  input  logic [31:0] IM_raddr,
  output logic [31:0] IM_rdata,
  input  logic        DM_ren,
  input  logic [3:0]  DM_wen,
  input  logic [31:0] DM_addr,
  input  logic [31:0] DM_wdata,
  output logic [31:0] DM_rdata,
  output logic        waiting,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        err
);

  state_e      state_q, state_d, after_dm;
  req_t        req_q, req_in;
  logic [31:0] im_rdata_q, im_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic        store_req, req_pending, capture;
  logic        in_service, expired, timeout_hit;

  assign store_req   = (DM_wen != WEN_NONE);
  assign req_pending = IM_ren | DM_ren | store_req;
  assign in_service  = (state_q == DM_REQ) || (state_q == DM_RESP) ||
                       (state_q == IM_REQ) || (state_q == IM_RESP);
  assign after_dm    = req_q.im_rd ? IM_REQ : DONE;

  // A store wins over a simultaneous load; the load is dropped.
  always_comb begin
    req_in          = '0;
    req_in.im_rd    = IM_ren;
    req_in.im_word  = IM_raddr[31:2];
    req_in.dm_rd    = DM_ren & ~store_req;
    req_in.dm_wr    = store_req;
    req_in.dm_word  = DM_addr[31:2];
    req_in.dm_wstrb = ~DM_wen;
    req_in.dm_wdata = DM_wdata;
  end

  always_comb begin
    state_d     = state_q;
    capture     = 1'b0;
    im_rdata_d  = im_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    timeout_hit = 1'b0;
    waiting     = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wstrb   = '0;
    mem_wdata   = '0;

    unique case (state_q)
      IDLE: begin
        waiting = req_pending & ~rst;
        if (req_pending) begin
          capture = 1'b1;
          state_d = (DM_ren | store_req) ? DM_REQ : IM_REQ;
        end
      end
      DM_REQ: begin
        waiting   = 1'b1;
        mem_req   = 1'b1;
        mem_we    = req_q.dm_wr;
        mem_addr  = word_addr(req_q.dm_word);
        mem_wstrb = req_q.dm_wstrb;
        mem_wdata = req_q.dm_wdata;
        if (mem_gnt) begin
          state_d = req_q.dm_wr ? after_dm : DM_RESP;
        end else if (expired) begin
          timeout_hit = 1'b1;
          state_d     = after_dm;
          if (req_q.dm_rd) begin
            dm_rdata_d = '0;
          end
        end
      end
      DM_RESP: begin
        waiting = 1'b1;
        if (mem_rvalid) begin
          dm_rdata_d = mem_rdata;
          state_d    = after_dm;
        end else if (expired) begin
          timeout_hit = 1'b1;
          dm_rdata_d  = '0;
          state_d     = after_dm;
        end
      end
      IM_REQ: begin
        waiting  = 1'b1;
        mem_req  = 1'b1;
        mem_addr = word_addr(req_q.im_word);
        if (mem_gnt) begin
          state_d = IM_RESP;
        end else if (expired) begin
          timeout_hit = 1'b1;
          im_rdata_d  = '0;
          state_d     = DONE;
        end
      end
      IM_RESP: begin
        waiting = 1'b1;
        if (mem_rvalid) begin
          im_rdata_d = mem_rdata;
          state_d    = DONE;
        end else if (expired) begin
          timeout_hit = 1'b1;
          im_rdata_d  = '0;
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      req_q      <= '0;
      im_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      im_rdata_q <= im_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      if (capture) begin
        req_q <= req_in;
      end
    end
  end

  assign IM_rdata = im_rdata_q;
  assign DM_rdata = dm_rdata_q;

`ifdef MEM_TIMEOUT_EN
  logic err_q;

  mem_req_watchdog #(
    .LIMIT(TIMEOUT_CYC)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .run_i    (in_service),
    .clear_i  (state_d != state_q),
    .expired_o(expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= timeout_hit;
    end
  end

  assign err = err_q;
`else
  assign expired = 1'b0;
  assign err     = 1'b0;
`endif

  // Byte-offset bits are dropped by word alignment; the rest matter only with the timeout.
  logic unused_ok;
  assign unused_ok = ^{IM_raddr[1:0], DM_addr[1:0], timeout_hit, in_service,
                       (TIMEOUT_CYC == 0)};

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench for cpu_mem_responder: directed table, randomized
// transactions against a transaction-level model, and reset/timeout sequences.
module tb_cpu_mem_responder;

  localparam int unsigned TO_CYC = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        IM_ren;
  logic [31:0] IM_raddr;
  logic [31:0] IM_rdata;
  logic        DM_ren;
  logic [3:0]  DM_wen;
  logic [31:0] DM_addr;
  logic [31:0] DM_wdata;
  logic [31:0] DM_rdata;
  logic        waiting;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        err;

  always #5 clk = ~clk;

  cpu_mem_responder #(
    .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .IM_ren    (IM_ren),
    .IM_raddr  (IM_raddr),
    .IM_rdata  (IM_rdata),
    .DM_ren    (DM_ren),
    .DM_wen    (DM_wen),
    .DM_addr   (DM_addr),
    .DM_wdata  (DM_wdata),
    .DM_rdata  (DM_rdata),
    .waiting   (waiting),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wstrb (mem_wstrb),
    .mem_wdata (mem_wdata),
    .mem_gnt   (mem_gnt),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata),
    .err       (err)
  );

  // One CPU request plus backend timing/data for up to two beats.
  typedef struct {
    logic        im_ren;
    logic [31:0] im_addr;
    logic        dm_ren;
    logic [3:0]  dm_wen;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    int          gd0;
    int          rd0;
    logic [31:0] d0;
    int          gd1;
    int          rd1;
    logic [31:0] d1;
    int          exp_wait;
  } vec_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } beat_t;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_im = 32'h0;
  logic [31:0] exp_dm = 32'h0;
  vec_t        tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    IM_ren   = 1'b0;
    DM_ren   = 1'b0;
    DM_wen   = 4'hF;
    IM_raddr = $urandom();
    DM_addr  = $urandom();
    DM_wdata = $urandom();
  endtask

  function automatic vec_t mk(logic im_ren, logic [31:0] im_addr, logic dm_ren,
                              logic [3:0] dm_wen, logic [31:0] dm_addr,
                              logic [31:0] dm_wdata, int gd0, int rd0, logic [31:0] d0,
                              int gd1, int rd1, logic [31:0] d1, int exp_wait);
    vec_t v;
    v.im_ren = im_ren;  v.im_addr = im_addr;  v.dm_ren = dm_ren;
    v.dm_wen = dm_wen;  v.dm_addr = dm_addr;  v.dm_wdata = dm_wdata;
    v.gd0 = gd0;  v.rd0 = rd0;  v.d0 = d0;
    v.gd1 = gd1;  v.rd1 = rd1;  v.d1 = d1;
    v.exp_wait = exp_wait;
    return v;
  endfunction

  function automatic int gd_of(vec_t v, int b);
    return (b == 0) ? v.gd0 : v.gd1;
  endfunction

  function automatic int rd_of(vec_t v, int b);
    return (b == 0) ? v.rd0 : v.rd1;
  endfunction

  function automatic logic [31:0] data_of(vec_t v, int b);
    return (b == 0) ? v.d0 : v.d1;
  endfunction

  // Apply one request, act as the backend, and compare the whole transaction.
  task automatic run_txn(input string tag, input vec_t v);
    beat_t exp_q[$];
    beat_t obs_q[$];
    beat_t cur;
    int    exp_wait, n_wait, b, req_cyc, rv_cyc, dm_beats;
    bit    in_resp, stable, timed_out;

    dm_beats = 0;
    if (v.dm_wen != 4'hF) begin
      exp_q.push_back('{1'b1, v.dm_addr & 32'hFFFF_FFFC, ~v.dm_wen, v.dm_wdata});
      dm_beats = 1;
    end else if (v.dm_ren) begin
      exp_q.push_back('{1'b0, v.dm_addr & 32'hFFFF_FFFC, 4'h0, 32'h0});
      dm_beats = 1;
    end
    if (v.im_ren) begin
      exp_q.push_back('{1'b0, v.im_addr & 32'hFFFF_FFFC, 4'h0, 32'h0});
    end

    exp_wait = 1;
    foreach (exp_q[i]) begin
      exp_wait += gd_of(v, i) + 1 + (exp_q[i].we ? 0 : rd_of(v, i));
    end
    if (v.exp_wait != 0) begin
      exp_wait = v.exp_wait;
    end

    @(negedge clk);
    IM_ren   = v.im_ren;
    IM_raddr = v.im_addr;
    DM_ren   = v.dm_ren;
    DM_wen   = v.dm_wen;
    DM_addr  = v.dm_addr;
    DM_wdata = v.dm_wdata;
    #1;
    check($sformatf("%s.wait_in_idle", tag), {31'h0, waiting}, 32'h1);
    n_wait = 1;
    @(negedge clk);
    drive_idle();

    b = 0;  req_cyc = 0;  rv_cyc = 0;
    in_resp = 1'b0;  stable = 1'b1;  timed_out = 1'b0;
    forever begin
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom();
      if (!waiting) break;
      if (n_wait >= 100) begin
        timed_out = 1'b1;
        break;
      end
      n_wait++;
      if (!in_resp) begin
        cur = '{mem_we, mem_addr, mem_wstrb, mem_wdata};
        if (req_cyc == 0) obs_q.push_back(cur);
        else if (cur != obs_q[$]) stable = 1'b0;
        if (!mem_req) stable = 1'b0;
        if (req_cyc >= gd_of(v, b)) begin
          mem_gnt = 1'b1;
          req_cyc = 0;
          if (mem_we) b++;
          else begin
            in_resp = 1'b1;
            rv_cyc  = 0;
          end
        end else begin
          req_cyc++;
          mem_rvalid = 1'($urandom_range(0, 1));
        end
      end else begin
        rv_cyc++;
        if (rv_cyc >= rd_of(v, b)) begin
          mem_rvalid = 1'b1;
          mem_rdata  = data_of(v, b);
          in_resp    = 1'b0;
          b++;
        end
      end
      @(negedge clk);
    end

    check($sformatf("%s.bounded", tag), {31'h0, timed_out}, 32'h0);
    check($sformatf("%s.wait_cycles", tag), n_wait, exp_wait);
    check($sformatf("%s.beat_count", tag), obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check($sformatf("%s.beat%0d_addr", tag, i), obs_q[i].addr, exp_q[i].addr);
      check($sformatf("%s.beat%0d_we", tag, i), {31'h0, obs_q[i].we}, {31'h0, exp_q[i].we});
      check($sformatf("%s.beat%0d_wstrb", tag, i), {28'h0, obs_q[i].wstrb},
            {28'h0, exp_q[i].wstrb});
      if (exp_q[i].we) begin
        check($sformatf("%s.beat%0d_wdata", tag, i), obs_q[i].wdata, exp_q[i].wdata);
      end
    end
    check($sformatf("%s.req_stable", tag), {31'h0, stable}, 32'h1);

    if (v.dm_wen == 4'hF && v.dm_ren) exp_dm = v.d0;
    if (v.im_ren) exp_im = (dm_beats == 1) ? v.d1 : v.d0;
    check($sformatf("%s.IM_rdata", tag), IM_rdata, exp_im);
    check($sformatf("%s.DM_rdata", tag), DM_rdata, exp_dm);
    check($sformatf("%s.req_low_in_done", tag), {31'h0, mem_req}, 32'h0);
    check($sformatf("%s.err", tag), {31'h0, err}, 32'h0);
  endtask

  initial begin
    rst        = 1'b1;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    drive_idle();

    // Reset state, including a pending request that must not raise waiting.
    repeat (2) @(negedge clk);
    DM_ren = 1'b1;
    #1;
    check("rst.waiting", {31'h0, waiting}, 32'h0);
    check("rst.IM_rdata", IM_rdata, 32'h0);
    check("rst.DM_rdata", DM_rdata, 32'h0);
    check("rst.mem_req", {31'h0, mem_req}, 32'h0);
    check("rst.mem_we", {31'h0, mem_we}, 32'h0);
    check("rst.mem_addr", mem_addr, 32'h0);
    check("rst.mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
    check("rst.mem_wdata", mem_wdata, 32'h0);
    check("rst.err", {31'h0, err}, 32'h0);
    DM_ren = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle.no_request", {31'h0, waiting}, 32'h0);

    // Directed table: fetch, byte store, DM+IM, delayed grant, store+load+fetch, slow IM.
    tbl[0] = mk(1'b1, 32'h100, 1'b0, 4'hF, 32'h0, 32'h0,
                0, 1, 32'h0050_0093, 0, 1, 32'h0, 3);
    tbl[1] = mk(1'b0, 32'h0, 1'b0, 4'b0011, 32'h2002, 32'hAABB_CCDD,
                0, 1, 32'h0, 0, 1, 32'h0, 2);
    tbl[2] = mk(1'b1, 32'h104, 1'b1, 4'hF, 32'h3004, 32'h0,
                0, 1, 32'h1111_1111, 0, 1, 32'h2222_2222, 5);
    tbl[3] = mk(1'b0, 32'h0, 1'b1, 4'hF, 32'h5008, 32'h0,
                4, 1, 32'hCAFE_F00D, 0, 1, 32'h0, 7);
    tbl[4] = mk(1'b1, 32'h20C, 1'b1, 4'b1110, 32'h6001, 32'h0000_00EE,
                1, 1, 32'h0, 0, 2, 32'h3333_3333, 6);
    tbl[5] = mk(1'b1, 32'h3FF, 1'b0, 4'hF, 32'h0, 32'h0,
                2, 3, 32'h4444_4444, 0, 1, 32'h0, 7);
    foreach (tbl[i]) begin
      run_txn($sformatf("vec%0d", i), tbl[i]);
    end

    // Randomized transactions; waiting length comes from the model.
    for (int i = 0; i < 40; i++) begin
      vec_t v;
      v.im_ren   = 1'($urandom_range(0, 1));
      v.dm_ren   = 1'($urandom_range(0, 1));
      v.dm_wen   = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
      if (!v.im_ren && !v.dm_ren && v.dm_wen == 4'hF) v.im_ren = 1'b1;
      v.im_addr  = $urandom();
      v.dm_addr  = $urandom();
      v.dm_wdata = $urandom();
      v.gd0 = $urandom_range(0, 3);  v.rd0 = $urandom_range(1, 3);  v.d0 = $urandom();
      v.gd1 = $urandom_range(0, 3);  v.rd1 = $urandom_range(1, 3);  v.d1 = $urandom();
      v.exp_wait = 0;
      run_txn($sformatf("rnd%0d", i), v);
    end

`ifdef MEM_TIMEOUT_EN
    // Load granted but never answered: abort after TO_CYC response cycles.
    begin
      int n_wait;
      @(negedge clk);
      DM_ren  = 1'b1;
      DM_addr = 32'h7000;
      #1;
      n_wait = 1;
      @(negedge clk);
      drive_idle();
      for (int c = 0; c < 60; c++) begin
        mem_gnt    = mem_req;
        mem_rvalid = 1'b0;
        if (!waiting) break;
        n_wait++;
        @(negedge clk);
      end
      mem_gnt = 1'b0;
      check("tmo.wait_cycles", n_wait, 2 + TO_CYC);
      check("tmo.err_in_done", {31'h0, err}, 32'h1);
      check("tmo.DM_rdata", DM_rdata, 32'h0);
      exp_dm = 32'h0;
      @(negedge clk);
      check("tmo.err_pulse", {31'h0, err}, 32'h0);
    end
`endif

    // Reset while waiting for read data, then a late rvalid.
    @(negedge clk);
    DM_ren  = 1'b1;
    DM_addr = 32'h4000;
    @(negedge clk);
    drive_idle();
    check("rstmid.req", {31'h0, mem_req}, 32'h1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    check("rstmid.in_resp", {31'h0, waiting}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("rstmid.waiting", {31'h0, waiting}, 32'h0);
    check("rstmid.mem_req", {31'h0, mem_req}, 32'h0);
    check("rstmid.IM_rdata", IM_rdata, 32'h0);
    check("rstmid.DM_rdata", DM_rdata, 32'h0);
    check("rstmid.err", {31'h0, err}, 32'h0);
    @(negedge clk);
    rst        = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("late_rvalid.DM_rdata", DM_rdata, 32'h0);
    check("late_rvalid.waiting", {31'h0, waiting}, 32'h0);
    check("late_rvalid.mem_req", {31'h0, mem_req}, 32'h0);
    exp_im = 32'h0;
    exp_dm = 32'h0;

    run_txn("post_rst", tbl[2]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_mem_responder.md
CPU_MEM_RESPONDER -- requirements
Module: cpu_mem_responder

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255: backend wait cycles before abort; used only with MEM_TIMEOUT_EN.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  asynchronous reset, active-high.
REQ-005 IM_ren  in  1  instruction fetch request.
REQ-006 IM_raddr  in  32  fetch byte address.
REQ-007 IM_rdata  out  32  fetched instruction, registered.
REQ-008 DM_ren  in  1  data load request.
REQ-009 DM_wen  in  4  byte write enables, active-low; 4'b1111 means no store.
REQ-010 DM_addr  in  32  data byte address.
REQ-011 DM_wdata  in  32  store data, already lane-aligned.
REQ-012 DM_rdata  out  32  load data, registered, unshifted word.
REQ-013 waiting  out  1  CPU stall; high while any accepted request is unfinished.
REQ-014 mem_req  out  1  backend request.
REQ-015 mem_we  out  1  backend write.
REQ-016 mem_addr  out  32  word-aligned address, bits [1:0] = 0.
REQ-017 mem_wstrb  out  4  active-high byte strobes, equal to ~DM_wen.
REQ-018 mem_wdata  out  32  backend write data.
REQ-019 mem_gnt  in  1  backend accepts the request in the same cycle.
REQ-020 mem_rvalid  in  1  read data valid, at least 1 cycle after the read grant.
REQ-021 mem_rdata  in  32  backend read data.
REQ-022 err  out  1  one-cycle timeout pulse.

Function
REQ-023 FSM states: IDLE, DM_REQ, DM_RESP, IM_REQ, IM_RESP, DONE.
REQ-024 In IDLE, a pending request (IM_ren, DM_ren, or DM_wen != 4'hF) shall drive waiting high combinationally and latch all request fields at the next edge.
REQ-025 Service order: DM first, then IM; a state whose request is absent is skipped.
REQ-026 Store and DM_ren together: the store is performed and the load is ignored.
REQ-027 In a *_REQ state, mem_req shall be held with stable fields until mem_gnt.
REQ-028 A write grant goes directly to the next service or to DONE; a read grant goes to *_RESP.
REQ-029 In *_RESP, rvalid shall capture mem_rdata into IM_rdata or DM_rdata.
REQ-030 DONE shall last exactly one cycle with waiting = 0, then return to IDLE.
REQ-031 The CPU advances on the DONE edge, and new requests are sampled only in IDLE.
REQ-032 Minimum latency with gnt and rvalid immediate: DM-only read gives 3 waiting cycles; DM plus IM gives 5 waiting cycles.
REQ-033 IM_rdata and DM_rdata shall hold their last captured value until overwritten.
REQ-034 mem_rvalid outside a *_RESP state shall be ignored.

Reset
REQ-035 Reset state: FSM = IDLE; IM_rdata, DM_rdata, mem_* outputs and err = 0.
REQ-036 Reset mid-transaction shall abandon the transaction; waiting = 0 while rst is high.

Configuration
REQ-037 MEM_TIMEOUT_EN defined: a counter runs in *_REQ and *_RESP states.
REQ-038 Reaching TIMEOUT_CYC shall: abort the transfer, load 32'h0 into the target rdata, pulse err, and continue to the next service or DONE.
REQ-039 MEM_TIMEOUT_EN undefined: no counter is built, err is tied to 0, and the FSM waits indefinitely.

Structure
REQ-040 Package cpu_mem_pkg shall hold: the state enum, WEN_NONE = 4'hF, and the timeout counter width.
REQ-041 Sub-module mem_req_watchdog (counter plus expiry flag) is instantiated only under MEM_TIMEOUT_EN.

Verification
REQ-042 IM read 0x100, backend returns 0x00500093 one cycle after grant -> waiting high 3 cycles, then IM_rdata = 0x00500093 in DONE.
REQ-043 DM store addr 0x2002, DM_wen = 4'b0011, no IM -> mem_we = 1, mem_addr = 0x2000, mem_wstrb = 4'b1100; no rvalid is needed.
REQ-044 DM load plus IM fetch in the same cycle -> DM beat precedes IM beat, and both rdata values are valid in DONE.
REQ-045 mem_gnt delayed 4 cycles -> mem_req and fields are stable throughout, and waiting is extended by 4.
REQ-046 With MEM_TIMEOUT_EN, TIMEOUT_CYC = 8, no rvalid -> err pulse, DM_rdata = 0, FSM reaches DONE.
REQ-047 rst asserted in DM_RESP -> IDLE immediately, outputs are 0, and a late rvalid is ignored.
